// File: rtl/program_loader.sv
// Program loader: receives a length-prefixed stream of 16-bit instruction
// words plus a trailing checksum, writes the words into instruction memory
// and releases the processor only once the checksum has matched.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for start, processor held in reset
//   ST_LOAD  | accepting program words and writing them to memory
//   ST_CHECK | waiting for the checksum word
//   ST_DONE  | program loaded and verified, processor released
//   ST_ERR   | bad length or checksum mismatch, processor held
module program_loader #(
  parameter int MAX_WORDS = 256
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [15:0] length,
  input  logic        word_valid,
  input  logic [15:0] word_in,
  output logic        word_ready,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  // 17 bits so a MAX_WORDS of 65536 still compares correctly against length
  localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic [15:0] sum_q;
  logic        accept;
  logic        start_en;
  logic        len_bad;

  assign start_en = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                              (state_q == ST_ERR));
  assign len_bad  = (length == 16'd0) || ({1'b0, length} > MAX_LEN);
  assign accept   = word_valid && word_ready;

  assign word_ready = (state_q == ST_LOAD) || (state_q == ST_CHECK);
  assign cpu_hold   = (state_q != ST_DONE);
  assign done       = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERR);

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start_en) state_d = len_bad ? ST_ERR : ST_LOAD;
      end
      ST_LOAD: begin
        if (accept && ((cnt_q + 16'd1) == len_q)) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (accept) state_d = (word_in == sum_q) ? ST_DONE : ST_ERR;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Session bookkeeping and the one-cycle-latency memory write port
  always_ff @(posedge clock) begin
    if (!resetn) begin
      len_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= 1'b0;
      if (start_en && !len_bad) begin
        len_q <= length;
        cnt_q <= '0;
        sum_q <= '0;
      end else if ((state_q == ST_LOAD) && accept) begin
        mem_we    <= 1'b1;
        mem_addr  <= cnt_q;
        mem_wdata <= word_in;
        cnt_q     <= cnt_q + 16'd1;
        sum_q     <= sum_q + word_in;
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// loads checked against a model that predicts writes and outcome from the
// word list and its modulo-2^16 sum.
module tb_program_loader;

  localparam int MAXW = 16;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [15:0] length = '0;
  logic        word_valid = 1'b0;
  logic [15:0] word_in = '0;
  logic        word_ready, mem_we, cpu_hold, done, error;
  logic [15:0] mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail = 0;
  int wr_count = 0;
  logic [15:0] mem_img [int];

  program_loader #(.MAX_WORDS(MAXW)) dut (
    .clock(clock), .resetn(resetn), .start(start), .length(length),
    .word_valid(word_valid), .word_in(word_in), .word_ready(word_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // Records every write the instruction memory would see
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wr_count++;
      mem_img[int'(mem_addr)] = mem_wdata;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic start_session(input int n);
    start = 1'b1;
    length = 16'(n);
    step();
    start = 1'b0;
  endtask

  // Presents one word after 'gaps' idle cycles; for program words checks the
  // write that must appear on the cycle right after the accept.
  task automatic send_word(input logic [15:0] w, input int gaps,
                           input bit is_load, input int idx);
    for (int g = 0; g < gaps; g++) begin
      word_valid = 1'b0;
      word_in = 16'($urandom);
      step();
    end
    n_checks++;
    if (word_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL word_ready_before_accept got %b want 1", word_ready);
    end
    word_valid = 1'b1;
    word_in = w;
    step();
    word_valid = 1'b0;
    word_in = 16'($urandom);
    if (is_load) begin
      n_checks++;
      if (mem_we !== 1'b1 || mem_addr !== 16'(idx) || mem_wdata !== w) begin
        n_fail++;
        $display("FAIL write_after_accept got we=%b addr=%h data=%h want we=1 addr=%h data=%h",
                 mem_we, mem_addr, mem_wdata, 16'(idx), w);
      end
    end
  endtask

  task automatic check_outcome(input string name, input bit exp_done);
    n_checks++;
    if (done !== exp_done || error !== !exp_done || cpu_hold !== !exp_done ||
        word_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL %s got done=%b error=%b hold=%b ready=%b want done=%b error=%b hold=%b ready=0",
               name, done, error, cpu_hold, word_ready, exp_done, !exp_done, !exp_done);
    end
  endtask

  task automatic check_wr(input string name, input int exp_count);
    n_checks++;
    if (wr_count !== exp_count) begin
      n_fail++;
      $display("FAIL %s write count got %0d want %0d", name, wr_count, exp_count);
    end
  endtask

  // Full load from a word list; the model is the plain sum of the list
  task automatic run_load(input string name, input logic [15:0] words[$],
                          input bit good_chk, input int max_gap);
    int sum = 0;
    int base = wr_count;
    logic [15:0] chk;
    mem_img.delete();
    start_session(words.size());
    n_checks++;
    if (word_ready !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_start got ready=%b hold=%b done=%b err=%b want 1 1 0 0",
               name, word_ready, cpu_hold, done, error);
    end
    foreach (words[i]) begin
      sum = (sum + int'(words[i])) % 65536;
      send_word(words[i], $urandom_range(0, max_gap), 1'b1, i);
    end
    chk = 16'(sum);
    if (!good_chk) chk = chk ^ 16'(1 << $urandom_range(0, 15));
    send_word(chk, $urandom_range(0, max_gap), 1'b0, 0);
    step();
    check_outcome(name, good_chk);
    check_wr(name, base + words.size());
    foreach (words[i]) begin
      n_checks++;
      if (!mem_img.exists(i) || mem_img[i] !== words[i]) begin
        n_fail++;
        $display("FAIL %s mem[%0d] got %h want %h", name, i,
                 mem_img.exists(i) ? mem_img[i] : 16'hxxxx, words[i]);
      end
    end
  endtask

  task automatic test_reset();
    start = 1'b1;
    length = 16'd3;
    word_valid = 1'b1;
    apply_reset();
    start = 1'b0;
    word_valid = 1'b0;
    n_checks++;
    if (word_ready !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 ||
        mem_wdata !== 16'h0 || cpu_hold !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state got ready=%b we=%b addr=%h data=%h hold=%b done=%b err=%b want 0 0 0 0 1 0 0",
               word_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, error);
    end
  endtask

  task automatic test_normal();
    logic [15:0] w[$] = '{16'h1111, 16'h2222, 16'h3333};
    run_load("normal", w, 1'b1, 0);
  endtask

  task automatic test_mismatch();
    logic [15:0] w[$] = '{16'h1111, 16'h2222, 16'h3333};
    int base;
    start_session(3);
    base = wr_count;
    foreach (w[i]) send_word(w[i], 0, 1'b1, i);
    send_word(16'h6667, 0, 1'b0, 0);
    step();
    check_outcome("mismatch", 1'b0);
    check_wr("mismatch", base + 3);
  endtask

  task automatic test_bad_length();
    int base = wr_count;
    int lens[2] = '{0, MAXW + 1};
    foreach (lens[k]) begin
      start_session(lens[k]);
      word_valid = 1'b1;
      word_in = 16'h5A5A;
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (word_ready !== 1'b0 || error !== 1'b1 || cpu_hold !== 1'b1) begin
          n_fail++;
          $display("FAIL bad_length len=%0d got ready=%b err=%b hold=%b want 0 1 1",
                   lens[k], word_ready, error, cpu_hold);
        end
        step();
      end
      word_valid = 1'b0;
    end
    check_wr("bad_length", base);
  endtask

  task automatic test_backpressure();
    int base;
    start_session(2);
    base = wr_count;
    send_word(16'hFFFF, 0, 1'b1, 0);
    send_word(16'h0002, 2, 1'b1, 1);
    send_word(16'h0001, 1, 1'b0, 0);
    step();
    check_outcome("backpressure_wrap", 1'b1);
    check_wr("backpressure_wrap", base + 2);
  endtask

  task automatic test_reset_mid_load();
    logic [15:0] w[$] = '{16'hABCD};
    int base;
    start_session(4);
    base = wr_count;
    send_word(16'h0101, 0, 1'b1, 0);
    send_word(16'h0202, 0, 1'b1, 1);
    word_valid = 1'b1;
    word_in = 16'h0303;
    start = 1'b1;
    length = 16'd2;
    apply_reset();
    word_valid = 1'b0;
    start = 1'b0;
    n_checks++;
    if (word_ready !== 1'b0 || cpu_hold !== 1'b1 || mem_we !== 1'b0 ||
        done !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_load got ready=%b hold=%b we=%b done=%b err=%b want 0 1 0 0 0",
               word_ready, cpu_hold, mem_we, done, error);
    end
    step();
    step();
    check_wr("reset_mid_load", base + 2);
    run_load("after_reset", w, 1'b1, 0);
  endtask

  task automatic test_reload();
    start_session(1);
    n_checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reload_hold got hold=%b done=%b want 1 0", cpu_hold, done);
    end
    send_word(16'h0042, 1, 1'b1, 0);
    n_checks++;
    if (done !== 1'b0 || cpu_hold !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_before_chk got done=%b hold=%b want 0 1", done, cpu_hold);
    end
    send_word(16'h0042, 0, 1'b0, 0);
    check_outcome("reload", 1'b1);
  endtask

  task automatic test_ignore_start();
    int base;
    start_session(3);
    base = wr_count;
    send_word(16'h1000, 0, 1'b1, 0);
    start = 1'b1;
    length = 16'd0;
    step();
    start = 1'b0;
    n_checks++;
    if (word_ready !== 1'b1 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_start got ready=%b err=%b want 1 0", word_ready, error);
    end
    send_word(16'h2000, 0, 1'b1, 1);
    send_word(16'h3000, 0, 1'b1, 2);
    start = 1'b1;
    length = 16'd5;
    send_word(16'h6000, 0, 1'b0, 0);
    start = 1'b0;
    step();
    check_outcome("ignore_start", 1'b1);
    check_wr("ignore_start", base + 3);
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      logic [15:0] w[$];
      int n = (it == 0) ? MAXW : $urandom_range(1, MAXW);
      for (int i = 0; i < n; i++) w.push_back(16'($urandom));
      run_load($sformatf("random%0d", it), w, ($urandom_range(0, 1) == 1), 3);
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_reload();
    test_mismatch();
    test_bad_length();
    test_backpressure();
    test_reset_mid_load();
    test_ignore_start();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
